dct2d_seq: RTL and testbench

Parametrised 2-D separable-transform sequencer, the successor to the fixed 8x8 DCT controller. It drives an external 1-D transform engine through N row passes and N column passes over an NxN block. It holds intermediate row results in an internal transpose buffer. It adds a start/busy/done handshake, multi-channel source addressing, selectable output order and parametrised block size and data widths.

---
 rtl/dct2d_seq.sv | 143 ++++++++++++++
 tb/tb_dct2d_seq.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct2d_seq.sv
// dct2d_seq: sequences an external 1-D engine over N row and N column passes
// of an NxN block. Row results are held in an internal transpose buffer.
// Ports: clock/nreset (sync, active-low); start/channel/out_order in,
// busy/done out; src_addr/src_data source port; eng_* engine port;
// res_* result write port.
module dct2d_seq #(
   parameter int LOG2N     = 3,
   parameter int IN_WIDTH  = 8,
   parameter int FRAC_BITS = 4,
   parameter int DATA_W    = 16,
   parameter int NUM_CH    = 3,
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int N        = 1 << LOG2N,
   localparam int NN       = N * N
) (
   input  logic                      clock,
   input  logic                      nreset,
   input  logic                      start,
   input  logic [CH_W-1:0]           channel,
   input  logic                      out_order,
   output logic                      busy,
   output logic                      done,
   output logic [CH_W+2*LOG2N-1:0]   src_addr,
   input  logic [IN_WIDTH-1:0]       src_data,
   output logic                      eng_nreset,
   input  logic [LOG2N-1:0]          eng_fetch_addr,
   output logic [DATA_W-1:0]         eng_src_data,
   input  logic [LOG2N-1:0]          eng_result_addr,
   input  logic                      eng_result_wren,
   input  logic [DATA_W-1:0]         eng_result_data,
   input  logic                      eng_finished,
   output logic [2*LOG2N-1:0]        res_addr,
   output logic                      res_wren,
   output logic [DATA_W-1:0]         res_data,
   output logic [CH_W-1:0]           res_channel
);

   typedef enum logic [1:0] {
      IDLE,
      ENG_RST,
      ENG_RUN,
      FINISH
   } state_t;

   localparam logic [LOG2N:0] LAST = (LOG2N+1)'(2 * N - 1);

   state_t              state_q, state_d;
   logic [LOG2N:0]      line_q, line_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic                order_q, order_d;
   logic [DATA_W-1:0]   tbuf_q [NN];
   logic [DATA_W-1:0]   rd_q, rd_d;

   logic                pass2;
   logic [LOG2N-1:0]    l;
   logic                run;
   logic                tbuf_we;
   logic [2*LOG2N-1:0]  tbuf_wa;
   logic [2*LOG2N-1:0]  tbuf_ra;
   logic [DATA_W-1:0]   src_ext;

   assign pass2 = line_q[LOG2N];
   assign l     = line_q[LOG2N-1:0];
   assign run   = (state_q == ENG_RUN);

   always_comb begin
      state_d = state_q;
      line_d  = line_q;
      ch_d    = ch_q;
      order_d = order_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               ch_d    = channel;
               order_d = out_order;
               line_d  = '0;
               state_d = ENG_RST;
            end
         end
         ENG_RST: state_d = ENG_RUN;
         ENG_RUN: begin
            if (eng_finished) begin
               if (line_q == LAST) begin
                  state_d = FINISH;
               end else begin
                  line_d  = line_q + 1'b1;
                  state_d = ENG_RST;
               end
            end
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!nreset) begin
         state_q <= IDLE;
         line_q  <= '0;
         ch_q    <= '0;
         order_q <= 1'b0;
      end else begin
         state_q <= state_d;
         line_q  <= line_d;
         ch_q    <= ch_d;
         order_q <= order_d;
      end
   end

   // Pass 2 reads column-wise what pass 1 wrote row-wise.
   always_comb begin
      src_ext = DATA_W'($signed(src_data));
      tbuf_we = nreset && run && !pass2 && eng_result_wren;
      tbuf_wa = {l, eng_result_addr};
      tbuf_ra = {eng_fetch_addr, l};
      rd_d    = tbuf_q[tbuf_ra];
   end

   // Registered read gives the same one-cycle latency as the source port.
   always_ff @(posedge clock) begin
      if (tbuf_we) begin
         tbuf_q[tbuf_wa] <= eng_result_data;
      end
      rd_q <= rd_d;
   end

   always_comb begin
      busy         = (state_q != IDLE);
      done         = nreset && (state_q == FINISH);
      eng_nreset   = nreset && run;
      src_addr     = '0;
      if (state_q != IDLE) begin
         src_addr  = {ch_q, l, eng_fetch_addr};
      end
      eng_src_data = pass2 ? rd_q : (src_ext << FRAC_BITS);
      res_wren     = nreset && run && pass2 && eng_result_wren;
      res_data     = eng_result_data;
      res_channel  = ch_q;
      res_addr     = order_q ? {l, eng_result_addr}
                             : {eng_result_addr, l};
   end

endmodule

// File: tb/tb_dct2d_seq.sv
// tb_dct2d_seq: drives two dct2d_seq instances (8x8 and 4x4) with identity
// engine models and scoreboards every result write against computed values.
module tb_dct2d_seq;

   logic clock = 1'b0;
   logic nreset = 1'b0;
   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // ---------------- instance 0: N=8, 16-bit ----------------
   logic        start0 = 1'b0;
   logic [1:0]  ch0 = 2'd0;
   logic        ord0 = 1'b0;
   logic        busy0, done0, e0_nrst, res_wren0;
   logic [7:0]  src_addr0;
   logic [7:0]  src_data0;
   logic [15:0] e0_src, res_data0;
   logic [5:0]  res_addr0;
   logic [1:0]  res_ch0;
   logic [2:0]  e0_fetch, e0_raddr;
   logic        e0_wren, e0_fin;
   logic [7:0]  e0_cnt;
   logic        junk = 1'b0;
   logic        src_mode = 1'b0;

   dct2d_seq u0 (
      .clock(clock), .nreset(nreset), .start(start0),
      .channel(ch0), .out_order(ord0),
      .busy(busy0), .done(done0),
      .src_addr(src_addr0), .src_data(src_data0),
      .eng_nreset(e0_nrst), .eng_fetch_addr(e0_fetch),
      .eng_src_data(e0_src), .eng_result_addr(e0_raddr),
      .eng_result_wren(e0_wren), .eng_result_data(e0_src),
      .eng_finished(e0_fin),
      .res_addr(res_addr0), .res_wren(res_wren0),
      .res_data(res_data0), .res_channel(res_ch0)
   );

   always @(posedge clock) begin
      if (!e0_nrst) e0_cnt <= 8'd0;
      else if (e0_cnt != 8'hff) e0_cnt <= e0_cnt + 8'd1;
      src_data0 <= src_mode ? 8'h80 :
         8'(int'(src_addr0[5:3]) * 8 + int'(src_addr0[2:0]) - 32);
   end
   assign e0_fetch = e0_cnt[2:0];
   assign e0_wren  = junk || (e0_cnt >= 8'd1 && e0_cnt <= 8'd8);
   assign e0_raddr = 3'(e0_cnt - 8'd1);
   assign e0_fin   = (e0_cnt >= 8'd9);

   // ---------------- instance 1: N=4, 12-bit ----------------
   logic        start1 = 1'b0;
   logic [1:0]  ch1 = 2'd0;
   logic        busy1, done1, e1_nrst, res_wren1;
   logic [5:0]  src_addr1;
   logic [7:0]  src_data1;
   logic [11:0] e1_src, res_data1;
   logic [3:0]  res_addr1;
   logic [1:0]  res_ch1;
   logic [1:0]  e1_fetch, e1_raddr;
   logic        e1_wren, e1_fin;
   logic [7:0]  e1_cnt;

   dct2d_seq #(.LOG2N(2), .IN_WIDTH(8), .FRAC_BITS(3),
               .DATA_W(12), .NUM_CH(3)) u1 (
      .clock(clock), .nreset(nreset), .start(start1),
      .channel(ch1), .out_order(1'b0),
      .busy(busy1), .done(done1),
      .src_addr(src_addr1), .src_data(src_data1),
      .eng_nreset(e1_nrst), .eng_fetch_addr(e1_fetch),
      .eng_src_data(e1_src), .eng_result_addr(e1_raddr),
      .eng_result_wren(e1_wren), .eng_result_data(e1_src),
      .eng_finished(e1_fin),
      .res_addr(res_addr1), .res_wren(res_wren1),
      .res_data(res_data1), .res_channel(res_ch1)
   );

   always @(posedge clock) begin
      if (!e1_nrst) e1_cnt <= 8'd0;
      else if (e1_cnt != 8'hff) e1_cnt <= e1_cnt + 8'd1;
      src_data1 <= 8'(int'(src_addr1[3:2]) * 4 + int'(src_addr1[1:0]) - 8);
   end
   assign e1_fetch = e1_cnt[1:0];
   assign e1_wren  = (e1_cnt >= 8'd1 && e1_cnt <= 8'd4);
   assign e1_raddr = 2'(e1_cnt - 8'd1);
   assign e1_fin   = (e1_cnt >= 8'd5);

   // ---------------- scoreboard state ----------------
   logic [31:0] q0[$];
   logic [31:0] q1[$];
   logic [1:0]  exp_ch0 = 2'd0;
   logic [1:0]  exp_ch1 = 2'd0;
   int  dones0 = 0, dones1 = 0;
   int  t0 = 0, t1 = 0;
   bit  lat_en = 1'b0;
   logic pd0 = 1'b0, pd1 = 1'b0, pe0 = 1'b0, pe1 = 1'b0;
   int  e0_lines = 0, e1_resets = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push0(input logic ord, input bit m);
      logic [5:0]  a;
      logic [15:0] d;
      int v;
      for (int l = 0; l < 8; l++) begin
         for (int r = 0; r < 8; r++) begin
            a = ord ? 6'(l * 8 + r) : 6'(r * 8 + l);
            v = m ? -128 : r * 8 + l - 32;
            d = 16'(v * 16);
            q0.push_back({10'd0, a, d});
         end
      end
   endtask

   task automatic push1();
      logic [3:0]  a;
      logic [11:0] d;
      for (int l = 0; l < 4; l++) begin
         for (int r = 0; r < 4; r++) begin
            a = 4'(r * 4 + l);
            d = 12'((r * 4 + l - 8) * 8);
            q1.push_back({16'd0, a, d});
         end
      end
   endtask

   // One clock: sample outputs at the falling edge and score them.
   task automatic step();
      logic [31:0] e;
      @(negedge clock);
      cyc++;
      if (res_wren0) begin
         if (q0.size() == 0) begin
            chk("res0_extra_write", 32'(q0.size()), 32'd1);
         end else begin
            e = q0.pop_front();
            chk("res0", {10'd0, res_addr0, res_data0}, e);
            chk("res0_channel", 32'(res_ch0), 32'(exp_ch0));
         end
      end
      if (done0) begin
         dones0++;
         chk("done0_width", 32'(pd0), 32'd0);
         if (lat_en) chk("latency0", 32'(cyc - t0), 32'd177);
      end
      pd0 = done0;
      if (!busy0) e0_lines = 0;
      else if (e0_nrst && !pe0) e0_lines++;
      pe0 = e0_nrst;
      if (busy0 && e0_nrst && e0_lines >= 1 && e0_lines <= 8)
         chk("src_addr_ch", 32'(src_addr0[7:6]), 32'(exp_ch0));
      if (src_mode && busy0 && e0_nrst && e0_wren)
         chk("eng_src_m128", 32'(e0_src), 32'h0000F800);
      if (res_wren1) begin
         if (q1.size() == 0) begin
            chk("res1_extra_write", 32'(q1.size()), 32'd1);
         end else begin
            e = q1.pop_front();
            chk("res1", {16'd0, res_addr1, res_data1}, e);
            chk("res1_channel", 32'(res_ch1), 32'(exp_ch1));
         end
      end
      if (done1) begin
         dones1++;
         chk("done1_width", 32'(pd1), 32'd0);
         chk("latency1", 32'(cyc - t1), 32'd57);
      end
      pd1 = done1;
      if (e1_nrst && !pe1) e1_resets++;
      pe1 = e1_nrst;
   endtask

   task automatic go0(input logic [1:0] ch, input logic ord, input bit m);
      src_mode = m;
      exp_ch0 = ch;
      push0(ord, m);
      chk("busy0_before", 32'(busy0), 32'd0);
      start0 = 1'b1;
      ch0 = ch;
      ord0 = ord;
      t0 = cyc;
      step();
      start0 = 1'b0;
      ch0 = ~ch;
      ord0 = ~ord;
      chk("busy0_rise", 32'(busy0), 32'd1);
   endtask

   task automatic wait0(input int maxc);
      int d;
      d = dones0;
      for (int i = 0; i < maxc && dones0 == d; i++) step();
      chk("done0_seen", 32'(dones0 - d), 32'd1);
      chk("q0_drained", 32'(q0.size()), 32'd0);
      step();
      chk("busy0_idle", 32'(busy0), 32'd0);
   endtask

   initial begin
      int d, acc, run;
      logic pb;
      nreset = 1'b0;
      repeat (3) step();
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
      chk("rst_wren", 32'(res_wren0), 32'd0);
      chk("rst_eng_nreset", 32'(e0_nrst), 32'd0);
      chk("rst_src_addr", 32'(src_addr0), 32'd0);
      chk("rst_busy1", 32'(busy1), 32'd0);
      nreset = 1'b1;
      step();
      chk("idle_src_addr", 32'(src_addr0), 32'd0);

      // row-major identity, with latency
      lat_en = 1'b1;
      go0(2'd1, 1'b0, 1'b0);
      wait0(400);

      // transposed output; mid-block input changes must not matter
      go0(2'd1, 1'b1, 1'b0);
      wait0(400);
      d = dones0;
      repeat (5) step();
      chk("single_done", 32'(dones0 - d), 32'd0);

      // most negative sample
      go0(2'd0, 1'b0, 1'b1);
      wait0(400);
      src_mode = 1'b0;

      // stray engine strobes while idle
      junk = 1'b1;
      repeat (5) step();
      junk = 1'b0;
      chk("idle_no_wren", 32'(res_wren0), 32'd0);

      // reset in the middle of line 9
      lat_en = 1'b0;
      go0(2'd2, 1'b0, 1'b0);
      for (int i = 0; i < 400 && e0_lines != 10; i++) step();
      chk("line9_reached", 32'(e0_lines), 32'd10);
      repeat (3) step();
      nreset = 1'b0;
      step();
      chk("midrst_busy", 32'(busy0), 32'd0);
      chk("midrst_wren", 32'(res_wren0), 32'd0);
      chk("midrst_done", 32'(done0), 32'd0);
      nreset = 1'b1;
      q0.delete();
      d = dones0;
      repeat (200) step();
      chk("midrst_no_done", 32'(dones0 - d), 32'd0);
      lat_en = 1'b1;
      go0(2'd2, 1'b0, 1'b0);
      wait0(400);

      // start held high for 400 cycles
      lat_en = 1'b0;
      exp_ch0 = 2'd1;
      repeat (3) push0(1'b0, 1'b0);
      d = dones0;
      acc = 0;
      run = 0;
      pb = busy0;
      start0 = 1'b1;
      ch0 = 2'd1;
      ord0 = 1'b0;
      for (int i = 0; i < 400; i++) begin
         step();
         if (!busy0) begin
            run++;
         end else if (!pb) begin
            acc++;
            if (acc > 1) chk("idle_gap", 32'(run), 32'd1);
            run = 0;
         end
         pb = busy0;
      end
      start0 = 1'b0;
      chk("accepts", 32'(acc), 32'd3);
      chk("dones_in_window", 32'(dones0 - d), 32'd2);
      wait0(400);

      // 4x4 configuration
      exp_ch1 = 2'd2;
      push1();
      e1_resets = 0;
      start1 = 1'b1;
      ch1 = 2'd2;
      t1 = cyc;
      step();
      start1 = 1'b0;
      ch1 = 2'd0;
      d = dones1;
      for (int i = 0; i < 200 && dones1 == d; i++) step();
      chk("done1_seen", 32'(dones1 - d), 32'd1);
      chk("q1_drained", 32'(q1.size()), 32'd0);
      chk("eng1_resets", 32'(e1_resets), 32'd8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
